cdr_loop_filter: RTL and testbench
==================================

Name: cdr_loop_filter

Overview:
Digital loop filter between the bang-bang (Alexander) phase detector and the phase rotator in the CDR loop. It integrates per-cycle early/late votes in a signed accumulator. When a threshold is reached it issues a single-cycle inc or dec step command to the rotator, then enforces a hold-off window so the rotator and detector can settle. It also reports a lock indication derived from the correction pattern.

Parameters:
ACC_W, 5, accumulator width in bits (signed, two's complement)
THRESH, 8, vote magnitude that triggers a step; legal range 1 .. 2^(ACC_W-1)-1
HOLDOFF, 4, cycles after a step during which votes are discarded; 0 disables hold-off
LOCK_WIN, 64, consecutive counted votes without a same-direction repeat step required to assert locked
LOCK_W, 7, width of the quiet counter; must satisfy 2^LOCK_W > LOCK_WIN

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
en   in  1  vote qualifier from the phase detector; votes are ignored when 0
up   in  1  early vote: clock is late, so advance (maps to inc)
dn   in  1  late vote: clock is early, so retard (maps to dec)
inc  out 1  registered one-cycle step-forward pulse to the rotator
dec  out 1  registered one-cycle step-back pulse to the rotator
acc  out ACC_W  current accumulator value, signed; for observation only
locked out 1  lock indication, registered

Behaviour:
- Reset (rst=0, asynchronous): acc=0, inc=0, dec=0, locked=0, state=TRACK, hold_cnt=0, quiet_cnt=0, last_dir=NONE.
- Vote decode in TRACK with en=1:
  - up=1, dn=0 gives +1.
  - dn=1, up=0 gives -1.
  - up=dn=1 or up=dn=0 gives 0 (no change, not counted).
- acc_next = acc + vote.
- If acc_next == +THRESH: on the same edge set inc<=1, acc<=0, last_dir<=UP, and state<=HOLD with hold_cnt<=HOLDOFF (stay in TRACK if HOLDOFF=0).
- If acc_next == -THRESH: same as above, but drive dec and set last_dir<=DN.
- Otherwise: acc<=acc_next, inc<=0, dec<=0.
- Latency: the vote presented in cycle k that reaches threshold produces inc or dec high during cycle k+1 only.
- inc and dec are never high in the same cycle. Neither is ever high for two consecutive cycles.
- |acc| < THRESH at all times; no wrap or saturation logic is needed.
- HOLD state:
  - Votes are discarded regardless of en; acc is held at 0; inc and dec are 0.
  - hold_cnt decrements every cycle, independent of en.
  - When hold_cnt==1, next state is TRACK. HOLD therefore lasts exactly HOLDOFF cycles.
- en=0 in TRACK: acc is held, nothing is counted, no step is issued.
- Lock logic:
  - quiet_cnt increments on every nonzero vote accepted in TRACK and saturates at LOCK_WIN.
  - A step in the same direction as last_dir clears quiet_cnt to 0 and sets locked<=0.
  - A step in the opposite direction (normal bang-bang dither), or the first step after reset, leaves quiet_cnt unchanged.
  - locked<=1 on the edge where quiet_cnt reaches LOCK_WIN. It stays 1 until a same-direction repeat step or reset.
- Reset mid-HOLD or mid-pulse: all outputs return to reset values immediately. No pending step is issued after reset release.

Test Plan:
- Reset: drive rst=0 mid-stream with acc=5 -> acc=0, inc=dec=locked=0 asynchronously. First vote after release moves acc to +1.
- Threshold up: en=1, up=1 for 8 cycles -> acc steps 1..7, then inc=1 for exactly one cycle after the 8th vote, acc=0. The following 4 votes are ignored (acc stays 0). The 13th vote gives acc=1.
- Threshold down with gaps: 8 dn votes interleaved with en=0 cycles and up=dn=1 cycles -> acc reaches -7. dec pulses once, one cycle after the 8th dn. inc is never asserted.
- Cancellation: alternating up, dn for 100 cycles -> acc oscillates between 0 and 1, no inc/dec. locked=1 after the 64th counted vote.
- Dither vs. drift: with locked=1, apply 8 up, 4 idle, 8 dn -> inc then dec, locked stays 1. Then apply 8 more dn -> second dec, locked=0 and quiet_cnt=0.
- HOLDOFF=0 build: 16 consecutive up votes -> inc pulses exactly twice, one cycle after the 8th and 16th votes, with no dropped votes.

Source files
------------

// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: bang-bang CDR loop filter.
// Integrates early/late votes into a signed accumulator and issues
// one-cycle inc/dec step pulses to the phase rotator at +/-THRESH.
// After each step a hold-off window discards votes while the loop
// settles. A lock flag tracks long runs without a same-direction
// repeat step: drift clears it, bang-bang dither keeps it.
module cdr_loop_filter #(
  parameter int ACC_W    = 5,
  parameter int THRESH   = 8,
  parameter int HOLDOFF  = 4,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    dn,
  output logic                    inc,
  output logic                    dec,
  output logic signed [ACC_W-1:0] acc,
  output logic                    locked
);

  typedef enum logic {
    TRACK,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

  // The hold counter needs at least one bit even when hold-off is disabled
  localparam int HC_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic signed [ACC_W-1:0] POS_TH    = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] NEG_TH    = ACC_W'(-THRESH);
  localparam logic        [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLDOFF);
  localparam logic        [LOCK_W-1:0] QUIET_MAX = LOCK_W'(LOCK_WIN);

  state_t                  state, state_n;
  dir_t                    last_dir, last_dir_n;
  logic [HC_W-1:0]         hold_cnt, hold_cnt_n;
  logic [LOCK_W-1:0]       quiet_cnt, quiet_cnt_n;
  logic signed [ACC_W-1:0] acc_n;
  logic                    inc_n, dec_n, locked_n;

  logic signed [ACC_W-1:0] vote;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    counted;
  logic                    step_up, step_dn, repeat_step;

  // Next-state logic: vote decode, threshold detection, hold-off and lock tracking
  always_comb begin
    state_n     = state;
    last_dir_n  = last_dir;
    hold_cnt_n  = hold_cnt;
    quiet_cnt_n = quiet_cnt;
    acc_n       = acc;
    inc_n       = 1'b0;
    dec_n       = 1'b0;
    locked_n    = locked;
    vote        = '0;
    acc_sum     = acc;
    counted     = 1'b0;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    repeat_step = 1'b0;

    case (state)
      TRACK: begin
        if (en) begin
          if (up && !dn) begin
            vote = ACC_W'(1);
          end else if (dn && !up) begin
            vote = {ACC_W{1'b1}};
          end
        end
        counted = (vote != '0);
        acc_sum = acc + vote;
        step_up = counted && (acc_sum == POS_TH);
        step_dn = counted && (acc_sum == NEG_TH);
        repeat_step = (step_up && (last_dir == DIR_UP)) ||
                      (step_dn && (last_dir == DIR_DN));

        if (step_up || step_dn) begin
          acc_n      = '0;
          inc_n      = step_up;
          dec_n      = step_dn;
          last_dir_n = step_up ? DIR_UP : DIR_DN;
          if (HOLDOFF != 0) begin
            state_n    = HOLD;
            hold_cnt_n = HOLD_LOAD;
          end
          if (repeat_step) begin
            quiet_cnt_n = '0;
            locked_n    = 1'b0;
          end
        end else begin
          acc_n = acc_sum;
          if (counted && (quiet_cnt != QUIET_MAX)) begin
            quiet_cnt_n = quiet_cnt + LOCK_W'(1);
          end
        end

        if (quiet_cnt_n == QUIET_MAX) begin
          locked_n = 1'b1;
        end
      end

      HOLD: begin
        acc_n      = '0;
        hold_cnt_n = hold_cnt - HC_W'(1);
        if (hold_cnt <= HC_W'(1)) begin
          state_n = TRACK;
        end
      end

      default: begin
        state_n = TRACK;
      end
    endcase
  end

  // State and output registers; reset clears any pending step or hold-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= TRACK;
      last_dir  <= DIR_NONE;
      hold_cnt  <= '0;
      quiet_cnt <= '0;
      acc       <= '0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      last_dir  <= last_dir_n;
      hold_cnt  <= hold_cnt_n;
      quiet_cnt <= quiet_cnt_n;
      acc       <= acc_n;
      inc       <= inc_n;
      dec       <= dec_n;
      locked    <= locked_n;
    end
  end

endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter: checks cdr_loop_filter against a behavioural model
// through a scoreboard queue, plus a vector table and hand-written
// sequences for reset, lock/dither and the zero hold-off build.
module tb_cdr_loop_filter;

  localparam int ACC_W    = 5;
  localparam int THRESH   = 8;
  localparam int HOLDOFF  = 4;
  localparam int LOCK_WIN = 64;
  localparam int LOCK_W   = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic up  = 1'b0;
  logic dn  = 1'b0;

  logic                    inc, dec, locked;
  logic signed [ACC_W-1:0] acc;
  logic                    inc0, dec0, locked0;
  logic signed [ACC_W-1:0] acc0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rstBefore;
    logic e;
    logic u;
    logic d;
    int   expAcc;
    logic expInc;
    logic expDec;
  } vec_t;

  typedef struct {
    int   acc;
    logic inc;
    logic dec;
    logic locked;
  } exp_t;

  vec_t vecs[27];
  exp_t sbq[$];

  int   mAcc;
  int   mHold;
  int   mDir;
  int   mQuiet;
  logic mInc;
  logic mDec;
  logic mLocked;

  cdr_loop_filter #(
    .ACC_W(ACC_W), .THRESH(THRESH), .HOLDOFF(HOLDOFF),
    .LOCK_WIN(LOCK_WIN), .LOCK_W(LOCK_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .inc(inc), .dec(dec), .acc(acc), .locked(locked)
  );

  cdr_loop_filter #(
    .ACC_W(ACC_W), .THRESH(THRESH), .HOLDOFF(0),
    .LOCK_WIN(LOCK_WIN), .LOCK_W(LOCK_W)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .inc(inc0), .dec(dec0), .acc(acc0), .locked(locked0)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic r, input logic e, input logic u, input logic d,
                                 input int a, input logic i, input logic k);
    vec_t v;
    v.rstBefore = r;
    v.e = e;
    v.u = u;
    v.d = d;
    v.expAcc = a;
    v.expInc = i;
    v.expDec = k;
    return v;
  endfunction

  task automatic modelReset();
    mAcc    = 0;
    mHold   = 0;
    mDir    = 0;
    mQuiet  = 0;
    mInc    = 1'b0;
    mDec    = 1'b0;
    mLocked = 1'b0;
  endtask

  // Behavioural model: mHold counts remaining discarded cycles after a step
  task automatic modelStep(input logic e, input logic u, input logic d);
    int v;
    int s;
    int dir;
    mInc = 1'b0;
    mDec = 1'b0;
    if (mHold > 0) begin
      mHold--;
      mAcc = 0;
    end else begin
      v = 0;
      if (e && u && !d) v = 1;
      if (e && d && !u) v = -1;
      if (v != 0) begin
        s = mAcc + v;
        if (s == THRESH || s == -THRESH) begin
          dir = (s > 0) ? 1 : 2;
          if (mDir == dir) begin
            mQuiet  = 0;
            mLocked = 1'b0;
          end
          mDir  = dir;
          mAcc  = 0;
          mHold = HOLDOFF;
          mInc  = (dir == 1);
          mDec  = (dir == 2);
        end else begin
          mAcc = s;
          if (mQuiet < LOCK_WIN) mQuiet++;
          if (mQuiet == LOCK_WIN) mLocked = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs (at a falling edge) and queue the model's prediction
  task automatic applyStimulus(input logic e, input logic u, input logic d);
    exp_t x;
    en = e;
    up = u;
    dn = d;
    modelStep(e, u, d);
    x.acc    = mAcc;
    x.inc    = mInc;
    x.dec    = mDec;
    x.locked = mLocked;
    sbq.push_back(x);
  endtask

  // Wait past the rising edge and compare DUT outputs with the queued prediction
  task automatic checkOutput();
    exp_t x;
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      x = sbq.pop_front();
      chk("sb_acc", int'(acc), x.acc);
      chk("sb_inc", int'(inc), int'(x.inc));
      chk("sb_dec", int'(dec), int'(x.dec));
      chk("sb_locked", int'(locked), int'(x.locked));
    end
  endtask

  task automatic cycle(input logic e, input logic u, input logic d);
    applyStimulus(e, u, d);
    checkOutput();
  endtask

  // Assert reset between clock edges, verify outputs clear at once, release on a falling edge
  task automatic doReset();
    en = 1'b0;
    up = 1'b0;
    dn = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_acc", int'(acc), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst0_acc", int'(acc0), 0);
    chk("rst0_inc", int'(inc0), 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    sbq.delete();
  endtask

  initial begin
    // Threshold up: 8 votes to step, 4 discarded, 13th counts
    for (int i = 0; i < 7; i++) vecs[i] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, i + 1, 1'b0, 1'b0);
    vecs[7]  = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 8; i < 12; i++) vecs[i] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    vecs[12] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    // Threshold down with en=0 gaps and conflicting/empty votes
    vecs[13] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    vecs[14] = mkVec(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    vecs[15] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -2, 1'b0, 1'b0);
    vecs[16] = mkVec(1'b0, 1'b1, 1'b1, 1'b1, -2, 1'b0, 1'b0);
    vecs[17] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -3, 1'b0, 1'b0);
    vecs[18] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -4, 1'b0, 1'b0);
    vecs[19] = mkVec(1'b0, 1'b0, 1'b1, 1'b0, -4, 1'b0, 1'b0);
    vecs[20] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -5, 1'b0, 1'b0);
    vecs[21] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, -5, 1'b0, 1'b0);
    vecs[22] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -6, 1'b0, 1'b0);
    vecs[23] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, -7, 1'b0, 1'b0);
    vecs[24] = mkVec(1'b0, 1'b1, 1'b1, 1'b1, -7, 1'b0, 1'b0);
    vecs[25] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    vecs[26] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);

    modelReset();
    @(negedge clk);
    doReset();

    for (int i = 0; i < 27; i++) begin
      if (vecs[i].rstBefore) doReset();
      applyStimulus(vecs[i].e, vecs[i].u, vecs[i].d);
      checkOutput();
      chk($sformatf("vec%0d_acc", i), int'(acc), vecs[i].expAcc);
      chk($sformatf("vec%0d_inc", i), int'(inc), int'(vecs[i].expInc));
      chk($sformatf("vec%0d_dec", i), int'(dec), int'(vecs[i].expDec));
    end

    $display("[TB] async reset mid-stream");
    doReset();
    repeat (5) cycle(1'b1, 1'b1, 1'b0);
    chk("pre_rst_acc5", int'(acc), 5);
    doReset();
    cycle(1'b1, 1'b1, 1'b0);
    chk("post_rst_acc", int'(acc), 1);

    $display("[TB] reset during step pulse and hold-off");
    doReset();
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    chk("pulse_inc_seen", int'(inc), 1);
    doReset();
    cycle(1'b1, 1'b1, 1'b0);
    chk("after_pulse_rst_acc", int'(acc), 1);
    chk("after_pulse_rst_inc", int'(inc), 0);

    $display("[TB] cancellation and lock");
    doReset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, (i % 2) == 0, (i % 2) == 1);
      chk("cancel_inc", int'(inc), 0);
      chk("cancel_dec", int'(dec), 0);
      if (i == 62) chk("lock_before_64", int'(locked), 0);
      if (i == 63) chk("lock_at_64", int'(locked), 1);
    end
    chk("cancel_end_acc", int'(acc), 0);

    $display("[TB] dither versus drift");
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    chk("dither_inc", int'(inc), 1);
    chk("dither_locked_a", int'(locked), 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b1);
    chk("dither_dec", int'(dec), 1);
    chk("dither_locked_b", int'(locked), 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b1);
    chk("drift_dec", int'(dec), 1);
    chk("drift_locked", int'(locked), 0);
    chk("drift_quiet", int'(dut.quiet_cnt), 0);

    $display("[TB] zero hold-off build");
    doReset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      chk("h0_inc", int'(inc0), ((i == 7) || (i == 15)) ? 1 : 0);
      chk("h0_acc", int'(acc0), (i + 1) % 8);
      chk("h0_dec", int'(dec0), 0);
      chk("h0_locked", int'(locked0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
